// File: rtl/mdio_responder.sv
// mdio_responder: Clause 22 MDIO slave with a 32 x 16 register file.
// The station manager reads and writes registers over mdc/mdio. Local logic
// updates registers through upd_*. Registers 2 and 3 hold the PHY identifier
// and cannot be written.
//
// Ports:
//   clk, rst_n            system clock (>= 8x mdc), async active-low reset
//   mdc, mdio_in          MDIO clock and pad input (both async to clk)
//   mdio_out, mdio_oen    pad drive value and output disable (1 = released)
//   upd_en/addr/data      local register write port
//   wr_valid/addr/data    one-cycle notice of a completed MDIO write
//
// Build option: define MDIO_RESP_PREAMBLE_SUPPRESS_EN to accept a frame after a
// single preamble 1 instead of the full 32.
module mdio_responder #(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter logic [15:0] PHY_ID1  = 16'h0141,
  parameter logic [15:0] PHY_ID2  = 16'h0CC2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oen,
  input  logic        upd_en,
  input  logic [4:0]  upd_addr,
  input  logic [15:0] upd_data,
  output logic        wr_valid,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data
);

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned PRE_W    = 6;
  localparam int unsigned BCNT_W   = 5;
  localparam logic [PRE_W-1:0] PRE_MAX = 6'd32;

  typedef enum logic [2:0] {
    S_PRE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA
  } state_t;

  state_t state_q, state_d;

  logic [2:0] mdc_s;
  logic [1:0] mdio_s;
  logic       sample_c;
  logic       bit_c;
  logic       pre_ok_c;

  logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic              op_q, op_d;
  logic              rd_q, rd_d;
  logic              sel_q, sel_d;
  logic [3:0]        phy_sh_q, phy_sh_d;
  logic [3:0]        reg_sh_q, reg_sh_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;

  logic              mdio_out_d, mdio_oen_d, wr_valid_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [DATA_W-1:0] wr_data_d;
  logic              mdio_we_c;

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // Two-flop synchronizers; the third mdc flop detects the rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdc_s  <= 3'b000;
      mdio_s <= 2'b11;
    end else begin
      mdc_s  <= {mdc_s[1:0], mdc};
      mdio_s <= {mdio_s[0], mdio_in};
    end
  end

  assign sample_c = mdc_s[1] & ~mdc_s[2];
  assign bit_c    = mdio_s[1];

`ifdef MDIO_RESP_PREAMBLE_SUPPRESS_EN
  assign pre_ok_c = (pre_cnt_q != '0);
`else
  assign pre_ok_c = (pre_cnt_q == PRE_MAX);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_PRE;
    else        state_q <= state_d;
  end

  // Frame sequencing; advances only on sampling events.
  always_comb begin
    state_d = state_q;
    if (sample_c) begin
      case (state_q)
        S_PRE:   if (!bit_c && pre_ok_c) state_d = S_ST;
        S_ST:    state_d = bit_c ? S_OP : S_PRE;
        S_OP:    if (bit_cnt_q == 5'd1) state_d = (op_q ^ bit_c) ? S_PHYAD : S_PRE;
        S_PHYAD: if (bit_cnt_q == 5'd4) state_d = S_REGAD;
        S_REGAD: if (bit_cnt_q == 5'd4) state_d = S_TA;
        // A read turns the bus after one TA event; a write samples both TA bits.
        S_TA:    if (rd_q || bit_cnt_q == 5'd1) state_d = S_DATA;
        // A read needs one extra event to release the pad after bit 0.
        S_DATA:  if (bit_cnt_q == (rd_q ? 5'd16 : 5'd15)) state_d = S_PRE;
        default: state_d = S_PRE;
      endcase
    end
  end

  // Field capture, pad drive and write completion.
  always_comb begin
    pre_cnt_d  = pre_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    op_d       = op_q;
    rd_d       = rd_q;
    sel_d      = sel_q;
    phy_sh_d   = phy_sh_q;
    reg_sh_d   = reg_sh_q;
    reg_addr_d = reg_addr_q;
    shreg_d    = shreg_q;
    mdio_out_d = mdio_out;
    mdio_oen_d = mdio_oen;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr;
    wr_data_d  = wr_data;
    mdio_we_c  = 1'b0;
    if (sample_c) begin
      bit_cnt_d = (state_d != state_q) ? '0 : bit_cnt_q + 5'd1;
      if (state_q != S_PRE) pre_cnt_d = '0;
      case (state_q)
        S_PRE: begin
          if (!bit_c)                    pre_cnt_d = '0;
          else if (pre_cnt_q != PRE_MAX) pre_cnt_d = pre_cnt_q + 6'd1;
        end
        S_OP: begin
          op_d = bit_c;
          rd_d = op_q & ~bit_c;
        end
        S_PHYAD: begin
          phy_sh_d = {phy_sh_q[2:0], bit_c};
          if (bit_cnt_q == 5'd4) sel_d = ({phy_sh_q, bit_c} == PHY_ADDR);
        end
        S_REGAD: begin
          reg_sh_d = {reg_sh_q[2:0], bit_c};
          if (bit_cnt_q == 5'd4) begin
            reg_addr_d = {reg_sh_q, bit_c};
            shreg_d    = regs_q[{reg_sh_q, bit_c}];
          end
        end
        S_TA: begin
          if (rd_q && sel_q) begin
            mdio_oen_d = 1'b0;
            mdio_out_d = 1'b0;
          end
        end
        S_DATA: begin
          if (rd_q) begin
            if (bit_cnt_q == 5'd16) begin
              mdio_oen_d = 1'b1;
              mdio_out_d = 1'b1;
            end else begin
              if (sel_q) mdio_out_d = shreg_q[15];
              shreg_d = {shreg_q[14:0], 1'b0};
            end
          end else begin
            shreg_d = {shreg_q[14:0], bit_c};
            if (bit_cnt_q == 5'd15 && sel_q) begin
              mdio_we_c  = 1'b1;
              wr_valid_d = 1'b1;
              wr_addr_d  = reg_addr_q;
              wr_data_d  = {shreg_q[14:0], bit_c};
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      op_q       <= 1'b0;
      rd_q       <= 1'b0;
      sel_q      <= 1'b0;
      phy_sh_q   <= '0;
      reg_sh_q   <= '0;
      reg_addr_q <= '0;
      shreg_q    <= '0;
      mdio_out   <= 1'b1;
      mdio_oen   <= 1'b1;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      sel_q      <= sel_d;
      phy_sh_q   <= phy_sh_d;
      reg_sh_q   <= reg_sh_d;
      reg_addr_q <= reg_addr_d;
      shreg_q    <= shreg_d;
      mdio_out   <= mdio_out_d;
      mdio_oen   <= mdio_oen_d;
      wr_valid   <= wr_valid_d;
      wr_addr    <= wr_addr_d;
      wr_data    <= wr_data_d;
    end
  end

  // Register file; MDIO write has priority over a same-address local update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      regs_q[2] <= PHY_ID1;
      regs_q[3] <= PHY_ID2;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (i != 2 && i != 3) begin
          if (mdio_we_c && wr_addr_d == 5'(i))   regs_q[i] <= wr_data_d;
          else if (upd_en && upd_addr == 5'(i))  regs_q[i] <= upd_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdio_responder.sv
// Testbench for mdio_responder: drives whole MDIO frames from a station
// manager model and compares against a register-file reference model.
`timescale 1ns/1ps
module tb_mdio_responder;

  logic        clk = 1'b0;
  logic        rst_n, mdc, mdio_in, mdio_out, mdio_oen, upd_en, wr_valid;
  logic [4:0]  upd_addr, wr_addr;
  logic [15:0] upd_data, wr_data;

  int checks = 0;
  int failures = 0;

  localparam logic [4:0] PHY = 5'd1;

  mdio_responder dut (
    .clk(clk), .rst_n(rst_n), .mdc(mdc), .mdio_in(mdio_in),
    .mdio_out(mdio_out), .mdio_oen(mdio_oen),
    .upd_en(upd_en), .upd_addr(upd_addr), .upd_data(upd_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  // wr_valid observer
  int          wv_cycles = 0;
  logic [4:0]  cap_addr = '0;
  logic [15:0] cap_data = '0;
  always @(negedge clk) begin
    if (wr_valid === 1'b1) begin
      wv_cycles++;
      cap_addr = wr_addr;
      cap_data = wr_data;
    end
  end

  // reference register file
  logic [15:0] mregs [32];
  function automatic void model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 16'h0000;
    mregs[2] = 16'h0141;
    mregs[3] = 16'h0CC2;
  endfunction
  function automatic void model_wr(input logic [4:0] a, input logic [15:0] d);
    if (a != 5'd2 && a != 5'd3) mregs[a] = d;
  endfunction

  // frame results
  logic        s_oen, s_out;
  logic [15:0] fr_rdata;
  logic        fr_ta_ok, fr_pat_ok, fr_silent, fr_timeout;
  logic        fr_ab_pre, fr_ab_oen, fr_ab_out, fr_ab_wv;

  // Station manager: "00" flush, preamble, ST, OP, PHYAD, REGAD, TA, DATA.
  // The pad is sampled just before each mdc rise. Optional: reset at bit
  // abort_at, local update pulse after bit upd_at, local update held across
  // the final write bit (collide).
  task automatic run_frame(input int pre_len, input logic rd, input logic [4:0] phy,
                           input logic [4:0] ra, input logic [15:0] wd,
                           input int abort_at, input int upd_at, input logic collide,
                           input logic [4:0] ua, input logic [15:0] ud);
    logic bits[$];
    int ta_pos, p, last;
    bits = {};
    bits.push_back(1'b0); bits.push_back(1'b0);
    for (int i = 0; i < pre_len; i++) bits.push_back(1'b1);
    bits.push_back(1'b0); bits.push_back(1'b1);
    bits.push_back(rd);   bits.push_back(~rd);
    for (int i = 4; i >= 0; i--) bits.push_back(phy[i]);
    for (int i = 4; i >= 0; i--) bits.push_back(ra[i]);
    bits.push_back(1'b1); bits.push_back(rd);
    for (int i = 15; i >= 0; i--) bits.push_back(rd ? 1'b1 : wd[i]);
    ta_pos = pre_len + 16;
    last = bits.size() - 1;
    fr_rdata = '0; fr_ta_ok = 1'b1; fr_pat_ok = 1'b1; fr_silent = 1'b1; fr_timeout = 1'b0;
    @(negedge clk);
    for (int i = 0; i <= last; i++) begin
      mdc = 1'b0;
      mdio_in = bits[i];
      #73;
      s_oen = mdio_oen;
      s_out = mdio_out;
      if (i == abort_at) begin
        fr_ab_pre = s_oen;
        rst_n = 1'b0;
        #1;
        fr_ab_oen = mdio_oen;
        fr_ab_out = mdio_out;
        fr_ab_wv  = wr_valid;
        return;
      end
      if (collide && i == last) begin
        upd_en = 1'b1; upd_addr = ua; upd_data = ud;
      end
      #7;
      mdc = 1'b1;
      if (collide && i == last) begin
        fr_timeout = 1'b1;
        for (int k = 0; k < 12 && fr_timeout; k++) begin
          @(negedge clk);
          if (wr_valid === 1'b1) fr_timeout = 1'b0;
        end
        upd_en = 1'b0;
        #40;
      end else begin
        #80;
      end
      p = i - ta_pos;
      fr_pat_ok &= (s_oen === ((p >= 1 && p <= 17) ? 1'b0 : 1'b1));
      fr_silent &= (s_oen === 1'b1);
      if (p == 0) fr_ta_ok &= (s_oen === 1'b1);
      if (p == 1) fr_ta_ok &= (s_oen === 1'b0 && s_out === 1'b0);
      if (p >= 2 && p <= 17) fr_rdata[17 - p] = s_out;
      if (i == upd_at) begin
        @(negedge clk); upd_en = 1'b1; upd_addr = ua; upd_data = ud;
        @(negedge clk); upd_en = 1'b0;
      end
    end
  endtask

  task automatic local_upd(input logic [4:0] a, input logic [15:0] d);
    @(negedge clk); upd_en = 1'b1; upd_addr = a; upd_data = d;
    @(negedge clk); upd_en = 1'b0;
    model_wr(a, d);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (mdio_oen !== 1'b1) begin failures++; $display("FAIL reset_oen got=%b exp=1", mdio_oen); end
    checks++; if (mdio_out !== 1'b1) begin failures++; $display("FAIL reset_out got=%b exp=1", mdio_out); end
    checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL reset_wv got=%b exp=0", wr_valid); end
    checks++; if (wr_addr !== 5'd0) begin failures++; $display("FAIL reset_waddr got=%h exp=0", wr_addr); end
    checks++; if (wr_data !== 16'd0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", wr_data); end
    rst_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_read_id();
    run_frame(32, 1'b1, PHY, 5'd2, 16'h0, -1, -1, 1'b0, 5'd0, 16'h0);
    checks++; if (fr_ta_ok !== 1'b1) begin failures++; $display("FAIL id_ta got=%b exp=1", fr_ta_ok); end
    checks++; if (fr_pat_ok !== 1'b1) begin failures++; $display("FAIL id_oen_window got=%b exp=1", fr_pat_ok); end
    checks++; if (fr_rdata !== mregs[2]) begin failures++; $display("FAIL id1_data got=%h exp=%h", fr_rdata, mregs[2]); end
    checks++; if (mdio_oen !== 1'b1) begin failures++; $display("FAIL id_release got=%b exp=1", mdio_oen); end
    run_frame(32, 1'b1, PHY, 5'd3, 16'h0, -1, -1, 1'b0, 5'd0, 16'h0);
    checks++; if (fr_rdata !== mregs[3]) begin failures++; $display("FAIL id2_data got=%h exp=%h", fr_rdata, mregs[3]); end
  endtask

  task automatic test_write_read();
    int w0;
    w0 = wv_cycles;
    run_frame(32, 1'b0, PHY, 5'd4, 16'hA5C3, -1, -1, 1'b0, 5'd0, 16'h0);
    checks++; if (wv_cycles - w0 !== 1) begin failures++; $display("FAIL wr_pulse got=%0d exp=1", wv_cycles - w0); end
    checks++; if (cap_addr !== 5'd4) begin failures++; $display("FAIL wr_addr got=%h exp=4", cap_addr); end
    checks++; if (cap_data !== 16'hA5C3) begin failures++; $display("FAIL wr_data got=%h exp=a5c3", cap_data); end
    checks++; if (fr_silent !== 1'b1) begin failures++; $display("FAIL wr_no_drive got=%b exp=1", fr_silent); end
    model_wr(5'd4, 16'hA5C3);
    run_frame(32, 1'b1, PHY, 5'd4, 16'h0, -1, -1, 1'b0, 5'd0, 16'h0);
    checks++; if (fr_rdata !== mregs[4]) begin failures++; $display("FAIL wr_readback got=%h exp=%h", fr_rdata, mregs[4]); end
  endtask

  task automatic test_unselected();
    int w0;
    logic [15:0] d;
    run_frame(32, 1'b1, 5'd5, 5'd2, 16'h0, -1, -1, 1'b0, 5'd0, 16'h0);
    checks++; if (fr_silent !== 1'b1) begin failures++; $display("FAIL unsel_rd_drive got=%b exp=1", fr_silent); end
    d = 16'($urandom);
    w0 = wv_cycles;
    run_frame(32, 1'b0, 5'd5, 5'd6, d, -1, -1, 1'b0, 5'd0, 16'h0);
    checks++; if (wv_cycles - w0 !== 0) begin failures++; $display("FAIL unsel_wr_pulse got=%0d exp=0", wv_cycles - w0); end
    run_frame(32, 1'b1, PHY, 5'd6, 16'h0, -1, -1, 1'b0, 5'd0, 16'h0);
    checks++; if (fr_pat_ok !== 1'b1) begin failures++; $display("FAIL unsel_next_oen got=%b exp=1", fr_pat_ok); end
    checks++; if (fr_rdata !== mregs[6]) begin failures++; $display("FAIL unsel_next_data got=%h exp=%h", fr_rdata, mregs[6]); end
  endtask

  task automatic test_short_preamble();
    int w0, exp_wv;
    logic [15:0] d;
    run_frame(31, 1'b1, PHY, 5'd3, 16'h0, -1, -1, 1'b0, 5'd0, 16'h0);
`ifdef MDIO_RESP_PREAMBLE_SUPPRESS_EN
    checks++; if (fr_rdata !== mregs[3] || fr_pat_ok !== 1'b1) begin failures++; $display("FAIL short_pre_rd got=%h/%b exp=%h/1", fr_rdata, fr_pat_ok, mregs[3]); end
    exp_wv = 1;
`else
    checks++; if (fr_silent !== 1'b1) begin failures++; $display("FAIL short_pre_rd_drive got=%b exp=1", fr_silent); end
    exp_wv = 0;
`endif
    d = 16'($urandom);
    w0 = wv_cycles;
    run_frame(31, 1'b0, PHY, 5'd7, d, -1, -1, 1'b0, 5'd0, 16'h0);
    checks++; if (wv_cycles - w0 !== exp_wv) begin failures++; $display("FAIL short_pre_wr got=%0d exp=%0d", wv_cycles - w0, exp_wv); end
    if (exp_wv == 1) model_wr(5'd7, d);
    run_frame(32, 1'b1, PHY, 5'd7, 16'h0, -1, -1, 1'b0, 5'd0, 16'h0);
    checks++; if (fr_rdata !== mregs[7]) begin failures++; $display("FAIL short_pre_reg7 got=%h exp=%h", fr_rdata, mregs[7]); end
  endtask

  task automatic test_ro_write();
    int w0;
    logic [15:0] d;
    d = 16'($urandom) | 16'h8000;
    w0 = wv_cycles;
    run_frame(32, 1'b0, PHY, 5'd2, d, -1, -1, 1'b0, 5'd0, 16'h0);
    checks++; if (wv_cycles - w0 !== 1 || cap_addr !== 5'd2 || cap_data !== d) begin failures++; $display("FAIL ro_pulse got=%0d/%h/%h exp=1/02/%h", wv_cycles - w0, cap_addr, cap_data, d); end
    model_wr(5'd2, d);
    local_upd(5'd3, ~d);
    run_frame(32, 1'b1, PHY, 5'd2, 16'h0, -1, -1, 1'b0, 5'd0, 16'h0);
    checks++; if (fr_rdata !== mregs[2]) begin failures++; $display("FAIL ro_reg2 got=%h exp=%h", fr_rdata, mregs[2]); end
    run_frame(32, 1'b1, PHY, 5'd3, 16'h0, -1, -1, 1'b0, 5'd0, 16'h0);
    checks++; if (fr_rdata !== mregs[3]) begin failures++; $display("FAIL ro_reg3 got=%h exp=%h", fr_rdata, mregs[3]); end
  endtask

  task automatic test_local_during_read();
    logic [15:0] d1, d2;
    d1 = 16'($urandom); d2 = ~d1;
    local_upd(5'd10, d1);
    run_frame(32, 1'b1, PHY, 5'd10, 16'h0, -1, 32 + 16 + 5, 1'b0, 5'd10, d2);
    checks++; if (fr_rdata !== d1) begin failures++; $display("FAIL upd_mid_read got=%h exp=%h", fr_rdata, d1); end
    model_wr(5'd10, d2);
    run_frame(32, 1'b1, PHY, 5'd10, 16'h0, -1, -1, 1'b0, 5'd0, 16'h0);
    checks++; if (fr_rdata !== mregs[10]) begin failures++; $display("FAIL upd_after_read got=%h exp=%h", fr_rdata, mregs[10]); end
  endtask

  task automatic test_random();
    int r, w0, exp_wv;
    logic [4:0] a, b, phy;
    logic [15:0] d;
    for (int it = 0; it < 8; it++) begin
      r = int'($urandom_range(0, 2));
      a = 5'($urandom_range(0, 31));
      d = 16'($urandom);
      if (r == 0) begin
        local_upd(a, d);
      end else begin
        phy = (r == 1) ? PHY : 5'($urandom_range(2, 31));
        exp_wv = (r == 1) ? 1 : 0;
        w0 = wv_cycles;
        run_frame(32, 1'b0, phy, a, d, -1, -1, 1'b0, 5'd0, 16'h0);
        checks++; if (wv_cycles - w0 !== exp_wv) begin failures++; $display("FAIL rnd_wr_pulse it=%0d got=%0d exp=%0d", it, wv_cycles - w0, exp_wv); end
        if (r == 1) model_wr(a, d);
      end
      b = (it % 2 == 0) ? a : 5'($urandom_range(0, 31));
      run_frame(32, 1'b1, PHY, b, 16'h0, -1, -1, 1'b0, 5'd0, 16'h0);
      checks++; if (fr_rdata !== mregs[b]) begin failures++; $display("FAIL rnd_read it=%0d reg=%0d got=%h exp=%h", it, b, fr_rdata, mregs[b]); end
    end
  endtask

  task automatic test_collision();
    int w0;
    w0 = wv_cycles;
    run_frame(32, 1'b0, PHY, 5'd9, 16'h2222, -1, -1, 1'b1, 5'd9, 16'h1111);
    checks++; if (fr_timeout !== 1'b0) begin failures++; $display("FAIL coll_wv_timeout got=%b exp=0", fr_timeout); end
    checks++; if (wv_cycles - w0 !== 1) begin failures++; $display("FAIL coll_pulse got=%0d exp=1", wv_cycles - w0); end
    model_wr(5'd9, 16'h2222);
    run_frame(32, 1'b1, PHY, 5'd9, 16'h0, -1, -1, 1'b0, 5'd0, 16'h0);
    checks++; if (fr_rdata !== 16'h2222) begin failures++; $display("FAIL coll_reg9 got=%h exp=2222", fr_rdata); end
  endtask

  task automatic test_reset_mid_read();
    local_upd(5'd4, 16'h5AF0);
    run_frame(32, 1'b1, PHY, 5'd4, 16'h0, 32 + 16 + 10, -1, 1'b0, 5'd0, 16'h0);
    checks++; if (fr_ab_pre !== 1'b0) begin failures++; $display("FAIL mid_rst_was_driving got=%b exp=0", fr_ab_pre); end
    checks++; if (fr_ab_oen !== 1'b1 || fr_ab_out !== 1'b1) begin failures++; $display("FAIL mid_rst_pad got=%b/%b exp=1/1", fr_ab_oen, fr_ab_out); end
    checks++; if (fr_ab_wv !== 1'b0) begin failures++; $display("FAIL mid_rst_wv got=%b exp=0", fr_ab_wv); end
    #20;
    rst_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    run_frame(32, 1'b1, PHY, 5'd3, 16'h0, -1, -1, 1'b0, 5'd0, 16'h0);
    checks++; if (fr_rdata !== 16'h0CC2 || fr_pat_ok !== 1'b1) begin failures++; $display("FAIL post_rst_reg3 got=%h/%b exp=0cc2/1", fr_rdata, fr_pat_ok); end
    run_frame(32, 1'b1, PHY, 5'd4, 16'h0, -1, -1, 1'b0, 5'd0, 16'h0);
    checks++; if (fr_rdata !== mregs[4]) begin failures++; $display("FAIL post_rst_reg4 got=%h exp=%h", fr_rdata, mregs[4]); end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mdc = 1'b0; mdio_in = 1'b1;
    upd_en = 1'b0; upd_addr = '0; upd_data = '0;
    test_reset();
    test_read_id();
    test_write_read();
    test_unselected();
    test_short_preamble();
    test_ro_write();
    test_local_during_read();
    test_random();
    test_collision();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
